// File: rtl/pq_front_end.sv
`default_nettype none
// ============================================================================
// pq_front_end: insert FIFO and head-prefetch register in front of a priority queue.
// Rev 1.0
// ============================================================================
module pq_front_end #(
    parameter int KW         = 8,
    parameter int VW         = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [KW-1:0]    in_key_i,
    input  logic [VW-1:0]    in_val_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [KW-1:0]    out_key_o,
    output logic [VW-1:0]    out_val_o,
    output logic             pq_enq_o,
    output logic             pq_deq_o,
    output logic [KW-1:0]    pq_kvi_key_o,
    output logic [VW-1:0]    pq_kvi_val_o,
    input  logic [KW-1:0]    pq_kvo_key_i,
    input  logic [VW-1:0]    pq_kvo_val_i,
    input  logic             pq_busy_i,
    input  logic             pq_full_i,
    input  logic             pq_empty_i,
    output logic [CNT_W-1:0] enq_count_o,
    output logic [CNT_W-1:0] deq_count_o
);
    localparam int         AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT1_C   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR1_C   = AW'(1);
    localparam logic [CNT_W-1:0] STAT1_C = CNT_W'(1);
    localparam logic [0:0] ST_READY = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    logic [KW-1:0]    key_mem_q [FIFO_DEPTH];
    logic [VW-1:0]    val_mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic [0:0]       state_q, state_d;
    logic             rr_q, rr_d;
    logic             out_valid_q;
    logic [KW-1:0]    out_key_q, kvi_key_q;
    logic [VW-1:0]    out_val_q, kvi_val_q;
    logic             enq_q, deq_q;
    logic [CNT_W-1:0] enq_cnt_q, deq_cnt_q;

    logic w_fifo_full, w_push, w_can_issue, w_ins_c, w_deq_c, w_do_enq, w_do_deq;

    always_comb begin
        w_fifo_full = (count_q == DEPTH_C);
        w_push      = in_valid_i && !w_fifo_full;
        w_can_issue = (state_q == ST_READY) && !pq_busy_i;
        w_ins_c     = w_can_issue && (count_q != '0) && !pq_full_i;
        w_deq_c     = w_can_issue && !pq_empty_i && (!out_valid_q || out_ready_i);
        // A full FIFO overrides round-robin so inserts cannot be starved.
        w_do_enq    = w_ins_c && (!w_deq_c || w_fifo_full || rr_q);
        w_do_deq    = w_deq_c && !w_do_enq;

        rr_d = rr_q;
        if (w_ins_c && w_deq_c && !w_fifo_full)
            rr_d = !rr_q;

        count_d = count_q;
        if (w_push && !w_do_enq)
            count_d = count_q + CNT1_C;
        else if (!w_push && w_do_enq)
            count_d = count_q - CNT1_C;

        state_d = state_q;
        case (state_q)
            ST_READY: if (w_do_enq || w_do_deq) state_d = ST_HOLD;
            ST_HOLD:  state_d = ST_READY;
            default:  state_d = ST_READY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            key_mem_q[wr_ptr_q] <= in_key_i;
            val_mem_q[wr_ptr_q] <= in_val_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= ST_READY;
            rr_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_key_q   <= '0;
            out_val_q   <= '0;
            kvi_key_q   <= '0;
            kvi_val_q   <= '0;
            enq_q       <= 1'b0;
            deq_q       <= 1'b0;
            enq_cnt_q   <= '0;
            deq_cnt_q   <= '0;
        end else begin
            count_q <= count_d;
            state_q <= state_d;
            rr_q    <= rr_d;
            enq_q   <= w_do_enq;
            deq_q   <= w_do_deq;
            if (w_push)
                wr_ptr_q <= wr_ptr_q + PTR1_C;
            if (w_do_enq) begin
                rd_ptr_q  <= rd_ptr_q + PTR1_C;
                kvi_key_q <= key_mem_q[rd_ptr_q];
                kvi_val_q <= val_mem_q[rd_ptr_q];
                enq_cnt_q <= enq_cnt_q + STAT1_C;
            end
            // Capturing the head also covers a same-cycle out handshake.
            if (w_do_deq) begin
                out_valid_q <= 1'b1;
                out_key_q   <= pq_kvo_key_i;
                out_val_q   <= pq_kvo_val_i;
                deq_cnt_q   <= deq_cnt_q + STAT1_C;
            end else if (out_valid_q && out_ready_i) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign in_ready_o   = !w_fifo_full;
    assign out_valid_o  = out_valid_q;
    assign out_key_o    = out_key_q;
    assign out_val_o    = out_val_q;
    assign pq_enq_o     = enq_q;
    assign pq_deq_o     = deq_q;
    assign pq_kvi_key_o = kvi_key_q;
    assign pq_kvi_val_o = kvi_val_q;
    assign enq_count_o  = enq_cnt_q;
    assign deq_count_o  = deq_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pq_front_end.sv
`default_nettype none
// ============================================================================
// tb_pq_front_end: bench for pq_front_end with a behavioural min-key PQ model.
// Rev 1.0
// ============================================================================
module tb_pq_front_end;
    localparam int KW = 8, VW = 8, DEPTH = 4, CW = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          in_valid = 0, out_ready = 0, pq_busy = 0, pq_full = 0, pq_empty = 1;
    logic [KW-1:0] in_key = 0, kvo_k = 0;
    logic [VW-1:0] in_val = 0, kvo_v = 0;
    logic          in_ready, out_valid, pq_enq, pq_deq;
    logic [KW-1:0] out_key, kvi_k;
    logic [VW-1:0] out_val, kvi_v;
    logic [CW-1:0] enq_count, deq_count;

    pq_front_end #(.KW(KW), .VW(VW), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_key_i(in_key), .in_val_i(in_val),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_key_o(out_key), .out_val_o(out_val),
        .pq_enq_o(pq_enq), .pq_deq_o(pq_deq), .pq_kvi_key_o(kvi_k), .pq_kvi_val_o(kvi_v),
        .pq_kvo_key_i(kvo_k), .pq_kvo_val_i(kvo_v),
        .pq_busy_i(pq_busy), .pq_full_i(pq_full), .pq_empty_i(pq_empty),
        .enq_count_o(enq_count), .deq_count_o(deq_count)
    );

    typedef struct packed {logic [7:0] k; logic [7:0] v;} kv_t;
    kv_t pq[$];
    kv_t enq_exp[$];
    kv_t out_exp[$];
    logic [7:0] out_log[$];
    int total = 0, bad = 0, enq_seen = 0, deq_seen = 0;
    logic prev_enq = 0, prev_deq = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic pq_refresh();
        pq_empty = (pq.size() == 0);
        kvo_k = (pq.size() != 0) ? pq[0].k : 8'h00;
        kvo_v = (pq.size() != 0) ? pq[0].v : 8'h00;
    endtask

    task automatic pq_ins(input kv_t x);
        int i = 0;
        while (i < pq.size() && pq[i].k <= x.k) i++;
        pq.insert(i, x);
        pq_refresh();
    endtask

    // PQ model plus scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (pq_enq && pq_deq) chk("enq_deq_overlap", 1, 0);
            if (pq_enq) begin
                chk("enq_width", {31'd0, prev_enq}, 0);
                if (enq_exp.size() == 0) chk("enq_unexpected", 1, 0);
                else begin
                    kv_t e;
                    e = enq_exp.pop_front();
                    chk("enq_kvi", {16'd0, kvi_k, kvi_v}, {16'd0, e.k, e.v});
                    pq_ins(e);
                end
                enq_seen++;
            end
            if (pq_deq) begin
                chk("deq_width", {31'd0, prev_deq}, 0);
                if (pq.size() == 0) chk("deq_on_empty", 1, 0);
                else begin
                    out_exp.push_back(pq.pop_front());
                    pq_refresh();
                end
                deq_seen++;
            end
            if (out_valid && out_ready) begin
                if (out_exp.size() == 0) chk("out_unexpected", 1, 0);
                else begin
                    kv_t o;
                    o = out_exp.pop_front();
                    chk("out_data", {16'd0, out_key, out_val}, {16'd0, o.k, o.v});
                end
                out_log.push_back(out_key);
            end
            prev_enq = pq_enq;
            prev_deq = pq_deq;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; in_valid = 0; pq_busy = 0; pq_full = 0; out_ready = 0;
        @(posedge clk);
        #1;
        pq.delete(); enq_exp.delete(); out_exp.delete(); out_log.delete();
        enq_seen = 0; deq_seen = 0; prev_enq = 0; prev_deq = 0;
        pq_refresh();
        rst = 0;
        step();
    endtask

    task automatic push(input logic [7:0] k, input logic [7:0] v);
        int n = 0;
        in_valid = 1; in_key = k; in_val = v;
        while (!in_ready && n < 50) begin step(); n++; end
        if (n >= 50) chk("push_timeout", 1, 0);
        else begin
            enq_exp.push_back({k, v});
            step();
        end
        in_valid = 0;
    endtask

    typedef struct {int n; int pq_n; bit full; int exp_op;} arb_t;
    arb_t tbl[8];

    initial begin
        int op, t0, t1;
        int seq[$];
        bit stable;

        // Asynchronous reset before any clock edge.
        #1 rst = 1;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 1);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_out_kv", {16'd0, out_key, out_val}, 0);
        chk("rst_strobes", {30'd0, pq_enq, pq_deq}, 0);
        chk("rst_kvi", {16'd0, kvi_k, kvi_v}, 0);
        chk("rst_counts", {enq_count, deq_count}, 0);

        // Single insert.
        do_reset();
        push(8'd5, 8'hA1);
        step();
        chk("s1_enq", {31'd0, pq_enq}, 1);
        chk("s1_kvi", {16'd0, kvi_k, kvi_v}, {16'd0, 8'd5, 8'hA1});
        chk("s1_enq_count", {16'd0, enq_count}, 1);
        chk("s1_in_ready", {31'd0, in_ready}, 1);
        step();
        chk("s1_enq_one_cycle", {31'd0, pq_enq}, 0);

        // Two dequeues 2 cycles apart, min key first.
        do_reset();
        pq_ins({8'd7, 8'h77}); pq_ins({8'd3, 8'h33});
        out_ready = 1;
        t0 = -1; t1 = -1;
        for (int c = 0; c < 12; c++) begin
            step();
            if (pq_deq) begin
                if (t0 < 0) t0 = c; else t1 = c;
            end
        end
        chk("s2_deq_spacing", t1 - t0, 2);
        chk("s2_out_count", out_log.size(), 2);
        if (out_log.size() == 2) begin
            chk("s2_first_key", {24'd0, out_log[0]}, 3);
            chk("s2_second_key", {24'd0, out_log[1]}, 7);
        end
        chk("s2_deq_count", {16'd0, deq_count}, 2);
        chk("s2_out_valid_end", {31'd0, out_valid}, 0);

        // Busy blocks all issue; FIFO fills then drains in order.
        do_reset();
        pq_busy = 1;
        push(8'd40, 8'h01); push(8'd30, 8'h02); push(8'd20, 8'h03); push(8'd10, 8'h04);
        repeat (6) step();
        chk("s3_no_strobes", enq_seen + deq_seen, 0);
        chk("s3_in_ready_full", {31'd0, in_ready}, 0);
        pq_busy = 0;
        repeat (20) step();
        chk("s3_enq_seen", enq_seen, 4);
        chk("s3_enq_count", {16'd0, enq_count}, 4);
        chk("s3_fifo_drained", enq_exp.size(), 0);

        // Round-robin alternation, deq first.
        do_reset();
        pq_busy = 1;
        pq_ins({8'd50, 8'h50}); pq_ins({8'd60, 8'h60}); pq_ins({8'd70, 8'h70});
        push(8'd1, 8'h11); push(8'd2, 8'h22);
        out_ready = 1;
        pq_busy = 0;
        seq.delete();
        for (int c = 0; c < 20 && seq.size() < 4; c++) begin
            step();
            if (pq_enq) seq.push_back(1);
            else if (pq_deq) seq.push_back(2);
        end
        chk("s4_seq_len", seq.size(), 4);
        if (seq.size() == 4)
            chk("s4_seq", {seq[0][7:0], seq[1][7:0], seq[2][7:0], seq[3][7:0]}, 32'h02010201);

        // Output stall, then streaming release.
        do_reset();
        pq_ins({8'd3, 8'hC3}); pq_ins({8'd7, 8'hC7});
        repeat (3) step();
        chk("s5_held_key", {24'd0, out_key}, 3);
        stable = 1;
        for (int c = 0; c < 20; c++) begin
            step();
            if (out_key != 8'd3 || out_val != 8'hC3 || !out_valid) stable = 0;
        end
        chk("s5_stable", {31'd0, stable}, 1);
        chk("s5_no_extra_deq", deq_seen, 1);
        out_ready = 1;
        step();
        chk("s5_deq_with_xfer", {31'd0, pq_deq}, 1);
        chk("s5_next_key", {24'd0, out_key}, 7);
        repeat (4) step();
        chk("s5_out_order", out_log.size(), 2);

        // Reset in the middle of a stream.
        do_reset();
        pq_ins({8'd3, 8'hD3});
        repeat (3) step();
        pq_busy = 1;
        push(8'd9, 8'h91); push(8'd8, 8'h81); push(8'd7, 8'h71);
        chk("s6_pre_out_valid", {31'd0, out_valid}, 1);
        #2 rst = 1;
        #1;
        chk("s6_async_out", {30'd0, out_valid, in_ready}, 1);
        chk("s6_async_kv", {out_key, out_val, kvi_k, kvi_v}, 0);
        chk("s6_async_counts", {enq_count, deq_count}, 0);
        pq.delete(); enq_exp.delete(); out_exp.delete(); pq_refresh();
        step();
        rst = 0; pq_busy = 0; enq_seen = 0; deq_seen = 0; prev_enq = 0; prev_deq = 0;
        repeat (10) step();
        chk("s6_no_strobe", enq_seen + deq_seen, 0);
        push(8'd4, 8'h44);
        repeat (3) step();
        chk("s6_new_enq", enq_seen, 1);

        // Arbitration table: {fifo items, pq items, pq_full, first op 0/1=enq/2=deq}.
        tbl[0] = '{1, 0, 0, 1};
        tbl[1] = '{0, 1, 0, 2};
        tbl[2] = '{2, 1, 0, 2};
        tbl[3] = '{4, 1, 0, 1};
        tbl[4] = '{2, 1, 1, 2};
        tbl[5] = '{0, 0, 0, 0};
        tbl[6] = '{4, 2, 1, 2};
        tbl[7] = '{1, 0, 1, 0};
        foreach (tbl[i]) begin
            do_reset();
            pq_busy = 1;
            pq_full = tbl[i].full;
            for (int j = 0; j < tbl[i].pq_n; j++) pq_ins({8'(90 + j), 8'(j)});
            for (int j = 0; j < tbl[i].n; j++) push(8'(20 + j), 8'(16 * i + j));
            out_ready = 1;
            pq_busy = 0;
            op = 0;
            for (int c = 0; c < 4 && op == 0; c++) begin
                step();
                if (pq_enq) op = 1;
                else if (pq_deq) op = 2;
            end
            chk($sformatf("arb_case%0d", i), op, tbl[i].exp_op);
            pq_full = 0;
            repeat (30) step();
            chk($sformatf("arb_drain%0d", i), enq_exp.size() + out_exp.size() + pq.size(), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule
`default_nettype wire
